// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller:
// default data width, command opcodes and controller state encodings.
package counter_seq_ctrl_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        OP_CLR  = 2'b00,
        OP_LOAD = 2'b01,
        OP_UP   = 2'b10,
        OP_DOWN = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_APPLY = 2'b01,
        S_RUN   = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    // UP and DOWN share opcode bit 1; CLR and LOAD are single-shot.
    function automatic logic op_is_count(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Command handshake bundle for counter_seq_ctrl.
// Ports: cmd_valid/cmd_op/cmd_arg from requester, cmd_ready back.
interface counter_seq_ctrl_if
    import counter_seq_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_N
);

    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [N-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );

endinterface

// File: rtl/counter_seq_ctrl_step_counter.sv
// Step down-counter: loads a step count, decrements on enable.
// Ports: clk, reset, load/load_val, dec; last flags one step left.
module counter_seq_ctrl_step_counter
    import counter_seq_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [N-1:0] remaining;

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_val;
        end else if (dec && remaining != '0) begin
            remaining <= remaining - 1'b1;
        end
    end

    assign last = (remaining == {{(N-1){1'b0}}, 1'b1});

endmodule

// File: rtl/universal_bin_counter.sv
// Universal binary counter: sync clear, load, up/down count.
// Ports: clk, reset, syn_clr, load, en, up, d; q, max_tick, min_tick.
module universal_bin_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    output logic         max_tick,
    output logic         min_tick,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (syn_clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en) begin
            if (up) q <= q + 1'b1;
            else    q <= q - 1'b1;
        end
    end

    assign max_tick = (q == {N{1'b1}});
    assign min_tick = (q == '0);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller that drives a universal binary counter
// from CLR/LOAD/UP/DOWN commands.
// Ports: clk, reset, cmd (slave handshake), pause, abort,
//        cnt_* strobes/data to counter, cnt_max/min_tick back,
//        done pulse with wrapped/aborted qualifiers.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                clk,
    input  logic                reset,
    counter_seq_ctrl_if.slave   cmd,
    input  logic                pause,
    input  logic                abort,
    output logic                cnt_en,
    output logic                cnt_up,
    output logic                cnt_syn_clr,
    output logic                cnt_load,
    output logic [N-1:0]        cnt_d,
    input  logic                cnt_max_tick,
    input  logic                cnt_min_tick,
    output logic                done,
    output logic                wrapped,
    output logic                aborted
);

    state_t       state;
    op_t          op_q;
    logic [N-1:0] arg_q;
    logic         wrap_q;
    logic         abort_q;

    logic         accept;
    logic         is_apply;
    logic         is_zero;
    logic         is_run;
    logic         run;
    logic         wrap_hit;
    logic         last;
    logic         step_load;

    assign accept   = cmd.cmd_valid && cmd.cmd_ready;
    assign is_apply = !op_is_count(cmd.cmd_op);
    assign is_zero  = op_is_count(cmd.cmd_op) && (cmd.cmd_arg == '0);
    assign is_run   = op_is_count(cmd.cmd_op) && (cmd.cmd_arg != '0);

    // Outputs are forced low during the reset cycle itself,
    // not just from the cycle after.
    assign run         = !reset && (state == S_RUN);
    assign cnt_en      = run && !pause && !abort;
    assign cnt_up      = run && (op_q == OP_UP);
    assign cnt_syn_clr = !reset && (state == S_APPLY)
                         && (op_q == OP_CLR);
    assign cnt_load    = !reset && (state == S_APPLY)
                         && (op_q == OP_LOAD);
    assign cnt_d       = cnt_load ? arg_q : '0;

    assign cmd.cmd_ready = !reset && (state == S_IDLE);

    assign done    = !reset && (state == S_DONE);
    assign wrapped = done && wrap_q;
    assign aborted = done && abort_q;

    // Wrap is seen on the enable that steps across the terminal value.
    assign wrap_hit = cnt_en && (cnt_up ? cnt_max_tick : cnt_min_tick);

    assign step_load = accept && is_run;

    counter_seq_ctrl_step_counter #(
        .N(N)
    ) step_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (step_load),
        .load_val (cmd.cmd_arg),
        .dec      (cnt_en),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            op_q    <= OP_CLR;
            arg_q   <= '0;
            wrap_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    wrap_q  <= 1'b0;
                    abort_q <= 1'b0;
                    if (accept) begin
                        op_q  <= op_t'(cmd.cmd_op);
                        arg_q <= cmd.cmd_arg;
                        unique case (1'b1)
                            is_apply: state <= S_APPLY;
                            is_zero:  state <= S_DONE;
                            is_run:   state <= S_RUN;
                            default:  state <= S_IDLE;
                        endcase
                    end
                end
                S_APPLY: begin
                    state <= S_DONE;
                end
                S_RUN: begin
                    if (abort) begin
                        abort_q <= 1'b1;
                        state   <= S_DONE;
                    end else if (cnt_en) begin
                        if (wrap_hit) wrap_q <= 1'b1;
                        if (last)     state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    wrap_q  <= 1'b0;
                    abort_q <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench: controller paired with universal_bin_counter,
// vector table plus hand-written pause/abort/reset sequences.
module tb_counter_seq_ctrl;
    import counter_seq_ctrl_pkg::*;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic         pause;
    logic         abort;
    logic         cnt_en;
    logic         cnt_up;
    logic         cnt_syn_clr;
    logic         cnt_load;
    logic [N-1:0] cnt_d;
    logic         max_tick;
    logic         min_tick;
    logic         done;
    logic         wrapped;
    logic         aborted;
    logic [N-1:0] q;

    int n_checks = 0;
    int n_errors = 0;

    counter_seq_ctrl_if #(.N(N)) cif ();

    counter_seq_ctrl #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd          (cif),
        .pause        (pause),
        .abort        (abort),
        .cnt_en       (cnt_en),
        .cnt_up       (cnt_up),
        .cnt_syn_clr  (cnt_syn_clr),
        .cnt_load     (cnt_load),
        .cnt_d        (cnt_d),
        .cnt_max_tick (max_tick),
        .cnt_min_tick (min_tick),
        .done         (done),
        .wrapped      (wrapped),
        .aborted      (aborted)
    );

    universal_bin_counter #(.N(N)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .syn_clr  (cnt_syn_clr),
        .load     (cnt_load),
        .en       (cnt_en),
        .up       (cnt_up),
        .d        (cnt_d),
        .max_tick (max_tick),
        .min_tick (min_tick),
        .q        (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [1:0] op;
        logic [7:0] arg;
        logic       ready;
        logic       en;
        logic       up;
        logic       clr;
        logic       ld;
        logic [7:0] d;
        logic       dn;
        logic       wr;
        logic       ab;
        logic [7:0] q;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic rst, input logic valid,
        input logic [1:0] op, input logic [7:0] arg,
        input logic ready, input logic en, input logic up,
        input logic clr, input logic ld, input logic [7:0] d,
        input logic dn, input logic wr, input logic ab,
        input logic [7:0] qv);
        vec_t v;
        v.rst = rst; v.valid = valid; v.op = op; v.arg = arg;
        v.ready = ready; v.en = en; v.up = up; v.clr = clr;
        v.ld = ld; v.d = d; v.dn = dn; v.wr = wr; v.ab = ab;
        v.q = qv;
        return v;
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a command and waits (bounded) for it to be accepted.
    task automatic offer(input logic [1:0] op, input logic [7:0] arg,
                         output logic ok);
        int n;
        ok = 1'b0;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_arg   = arg;
        n = 0;
        @(negedge clk);
        while (!cif.cmd_ready && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        ok = cif.cmd_ready;
        tick();
        cif.cmd_valid = 1'b0;
        cif.cmd_arg   = '0;
        check("offer_accepted", {31'd0, ok}, 32'd1);
    endtask

    // Runs one command to completion; lat = cycles accept-to-done.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg,
                           output int lat, output logic w,
                           output logic a, output logic ok);
        logic acc;
        ok = 1'b0; w = 1'b0; a = 1'b0; lat = 0;
        offer(op, arg, acc);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c; w = wrapped; a = aborted; ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        check("run_cmd_done_seen", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int   en_cnt;
        int   pcount;
        int   done_cyc;
        int   lat;
        logic got;
        logic ok;
        logic w;
        logic a;
        logic ab_sent;

        reset = 1'b1;
        pause = 1'b0;
        abort = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b00;
        cif.cmd_arg   = '0;
        repeat (2) tick();

        // rst valid op arg | ready en up clr ld d | done wr ab | q
        vq.push_back(mk(1,0,2'b00,8'h00, 0,0,0,0,0,8'h00, 0,0,0, 8'h00));
        vq.push_back(mk(0,0,2'b00,8'h00, 1,0,0,0,0,8'h00, 0,0,0, 8'h00));
        vq.push_back(mk(0,1,2'b01,8'hFD, 1,0,0,0,0,8'h00, 0,0,0, 8'h00));
        vq.push_back(mk(0,0,2'b00,8'h00, 0,0,0,0,1,8'hFD, 0,0,0, 8'h00));
        vq.push_back(mk(0,0,2'b00,8'h00, 0,0,0,0,0,8'h00, 1,0,0, 8'hFD));
        vq.push_back(mk(0,1,2'b10,8'h05, 1,0,0,0,0,8'h00, 0,0,0, 8'hFD));
        vq.push_back(mk(0,0,2'b00,8'h00, 0,1,1,0,0,8'h00, 0,0,0, 8'hFD));
        vq.push_back(mk(0,0,2'b00,8'h00, 0,1,1,0,0,8'h00, 0,0,0, 8'hFE));
        vq.push_back(mk(0,0,2'b00,8'h00, 0,1,1,0,0,8'h00, 0,0,0, 8'hFF));
        vq.push_back(mk(0,0,2'b00,8'h00, 0,1,1,0,0,8'h00, 0,0,0, 8'h00));
        vq.push_back(mk(0,0,2'b00,8'h00, 0,1,1,0,0,8'h00, 0,0,0, 8'h01));
        vq.push_back(mk(0,0,2'b00,8'h00, 0,0,0,0,0,8'h00, 1,1,0, 8'h02));
        vq.push_back(mk(0,1,2'b10,8'h00, 1,0,0,0,0,8'h00, 0,0,0, 8'h02));
        vq.push_back(mk(0,0,2'b00,8'h00, 0,0,0,0,0,8'h00, 1,0,0, 8'h02));
        vq.push_back(mk(0,1,2'b00,8'h77, 1,0,0,0,0,8'h00, 0,0,0, 8'h02));
        vq.push_back(mk(0,0,2'b00,8'h00, 0,0,0,1,0,8'h00, 0,0,0, 8'h02));
        vq.push_back(mk(0,0,2'b00,8'h00, 0,0,0,0,0,8'h00, 1,0,0, 8'h00));
        vq.push_back(mk(0,1,2'b01,8'h10, 1,0,0,0,0,8'h00, 0,0,0, 8'h00));
        vq.push_back(mk(0,0,2'b00,8'h00, 0,0,0,0,1,8'h10, 0,0,0, 8'h00));
        vq.push_back(mk(0,0,2'b00,8'h00, 0,0,0,0,0,8'h00, 1,0,0, 8'h10));

        foreach (vq[i]) begin
            reset         = vq[i].rst;
            cif.cmd_valid = vq[i].valid;
            cif.cmd_op    = vq[i].op;
            cif.cmd_arg   = vq[i].arg;
            @(negedge clk);
            check($sformatf("v%0d_ready", i), {31'd0, cif.cmd_ready}, {31'd0, vq[i].ready});
            check($sformatf("v%0d_en", i),    {31'd0, cnt_en},        {31'd0, vq[i].en});
            check($sformatf("v%0d_up", i),    {31'd0, cnt_up},        {31'd0, vq[i].up});
            check($sformatf("v%0d_clr", i),   {31'd0, cnt_syn_clr},   {31'd0, vq[i].clr});
            check($sformatf("v%0d_load", i),  {31'd0, cnt_load},      {31'd0, vq[i].ld});
            check($sformatf("v%0d_d", i),     {24'd0, cnt_d},         {24'd0, vq[i].d});
            check($sformatf("v%0d_done", i),  {31'd0, done},          {31'd0, vq[i].dn});
            check($sformatf("v%0d_wrap", i),  {31'd0, wrapped},       {31'd0, vq[i].wr});
            check($sformatf("v%0d_abrt", i),  {31'd0, aborted},       {31'd0, vq[i].ab});
            check($sformatf("v%0d_q", i),     {24'd0, q},             {24'd0, vq[i].q});
            tick();
        end
        reset = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_arg   = '0;

        // DOWN 3 from 0x10, pause held two cycles after first enable.
        offer(2'b11, 8'h03, ok);
        en_cnt = 0; pcount = 0; done_cyc = 0; got = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            pause = (en_cnt == 1 && pcount < 2);
            if (pause) pcount++;
            @(negedge clk);
            if (pause) check("down_pause_stalls", {31'd0, cnt_en}, 32'd0);
            if (cnt_en) en_cnt++;
            if (done) begin
                got = 1'b1; done_cyc = c;
                check("down_q", {24'd0, q}, 32'h0D);
                check("down_wrapped", {31'd0, wrapped}, 32'd0);
                check("down_aborted", {31'd0, aborted}, 32'd0);
                break;
            end
            tick();
        end
        pause = 1'b0;
        tick();
        check("down_done_seen", {31'd0, got}, 32'd1);
        check("down_enables", en_cnt, 3);
        check("down_latency", done_cyc, 6);

        // Abort while idle/applying is ignored.
        abort = 1'b1;
        run_cmd(2'b01, 8'h33, lat, w, a, ok);
        abort = 1'b0;
        check("idle_abort_ignored", {31'd0, a}, 32'd0);
        check("load_latency", lat, 2);
        check("load_q", {24'd0, q}, 32'h33);

        // CLR back to zero.
        run_cmd(2'b00, 8'h00, lat, w, a, ok);
        check("clr_q", {24'd0, q}, 32'h00);

        // UP 200, abort (with pause) after 10 enables.
        offer(2'b10, 8'd200, ok);
        en_cnt = 0; got = 1'b0; ab_sent = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (en_cnt == 10 && !ab_sent) begin
                pause = 1'b1; abort = 1'b1; ab_sent = 1'b1;
            end
            @(negedge clk);
            if (abort) check("abort_blocks_en", {31'd0, cnt_en}, 32'd0);
            if (cnt_en) en_cnt++;
            if (done) begin
                got = 1'b1;
                check("abort_flag", {31'd0, aborted}, 32'd1);
                check("abort_wrapped", {31'd0, wrapped}, 32'd0);
                check("abort_q", {24'd0, q}, 32'h0A);
                break;
            end
            tick();
            pause = 1'b0;
            abort = 1'b0;
        end
        tick();
        pause = 1'b0;
        abort = 1'b0;
        check("abort_done_seen", {31'd0, got}, 32'd1);
        check("abort_enables", en_cnt, 10);

        // Reset in the middle of a RUN.
        offer(2'b10, 8'd50, ok);
        en_cnt = 0;
        for (int c = 1; c <= 20 && en_cnt < 3; c++) begin
            @(negedge clk);
            if (cnt_en) en_cnt++;
            tick();
        end
        check("rst_pre_enables", en_cnt, 3);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, cif.cmd_ready}, 32'd0);
        check("rst_en", {31'd0, cnt_en}, 32'd0);
        check("rst_up", {31'd0, cnt_up}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        tick();
        reset = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || cnt_en) got = 1'b1;
            if (c == 0) begin
                check("rst_rel_ready", {31'd0, cif.cmd_ready}, 32'd1);
                check("rst_rel_q", {24'd0, q}, 32'h00);
            end
            tick();
        end
        check("rst_no_done_or_en", {31'd0, got}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
